// File: rtl/s_rr_pipe.sv
// rtl/s_rr_pipe.sv - pipelined circular find-first-set with round-robin start pointer
module s_rr_pipe #(
   parameter int W = 32,
   parameter int P_STAGES = 2,
   localparam int LW = $clog2(W)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          in_vld_i,
   output logic          in_rdy_o,
   input  logic [W-1:0]  x_i,
   input  logic [LW-1:0] pos_i,
   input  logic          dir_i,
   input  logic          use_ptr_i,
   output logic          out_vld_o,
   input  logic          out_rdy_i,
   output logic [W-1:0]  x_o,
   output logic [LW-1:0] pos_o,
   output logic          any_o,
   output logic [W-1:0]  y_o,
   output logic [LW-1:0] y_enc_o,
   output logic [LW-1:0] ptr_o
);

   logic          out_adv;
   logic          load;
   logic          srch_vld;
   logic [W-1:0]  srch_x;
   logic [LW-1:0] srch_pos;
   logic          srch_dir;
   logic          srch_use_ptr;
   logic [LW-1:0] eff_p;
   logic [LW-1:0] idx;
   logic [LW-1:0] enc;
   logic          any;
   logic          found;
   logic [W-1:0]  onehot;

   assign out_adv = !out_vld_o | out_rdy_i;
   assign load    = srch_vld & out_adv;

   generate
      if (P_STAGES == 2) begin : g_two
         logic          s1_vld;
         logic [W-1:0]  s1_x;
         logic [LW-1:0] s1_pos;
         logic          s1_dir;
         logic          s1_use_ptr;

         assign in_rdy_o = !s1_vld | out_adv;

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               s1_vld     <= 1'b0;
               s1_x       <= '0;
               s1_pos     <= '0;
               s1_dir     <= 1'b0;
               s1_use_ptr <= 1'b0;
            end else if (in_vld_i && in_rdy_o) begin
               s1_vld     <= 1'b1;
               s1_x       <= x_i;
               s1_pos     <= pos_i;
               s1_dir     <= dir_i;
               s1_use_ptr <= use_ptr_i;
            end else if (out_adv) begin
               s1_vld <= 1'b0;
            end
         end

         assign srch_vld     = s1_vld;
         assign srch_x       = s1_x;
         assign srch_pos     = s1_pos;
         assign srch_dir     = s1_dir;
         assign srch_use_ptr = s1_use_ptr;
      end else begin : g_one
         if (P_STAGES != 1) begin : g_bad
            $error("s_rr_pipe: P_STAGES must be 1 or 2");
         end

         assign in_rdy_o     = out_adv;
         assign srch_vld     = in_vld_i;
         assign srch_x       = x_i;
         assign srch_pos     = pos_i;
         assign srch_dir     = dir_i;
         assign srch_use_ptr = use_ptr_i;
      end
   endgenerate

   // The pointer is read when the search is evaluated, so back-to-back pointer beats chain correctly.
   always_comb begin
      eff_p  = srch_use_ptr ? ptr_o : srch_pos;
      any    = |srch_x;
      enc    = '0;
      idx    = '0;
      found  = 1'b0;
      for (int i = 0; i < W; i++) begin
         idx = srch_dir ? eff_p - LW'(i) : eff_p + LW'(i);
         if (!found && srch_x[idx]) begin
            found = 1'b1;
            enc   = idx;
         end
      end
      onehot = any ? (W'(1) << enc) : '0;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         out_vld_o <= 1'b0;
         x_o       <= '0;
         pos_o     <= '0;
         any_o     <= 1'b0;
         y_o       <= '0;
         y_enc_o   <= '0;
         ptr_o     <= '0;
      end else if (load) begin
         out_vld_o <= 1'b1;
         x_o       <= srch_x;
         pos_o     <= eff_p;
         any_o     <= any;
         y_o       <= onehot;
         y_enc_o   <= enc;
         if (srch_use_ptr && any) begin
            ptr_o <= srch_dir ? enc - LW'(1) : enc + LW'(1);
         end
      end else if (out_rdy_i) begin
         out_vld_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_s_rr_pipe.sv
// tb/tb_s_rr_pipe.sv - scoreboard bench for s_rr_pipe at both pipeline depths
module tb_s_rr_pipe;
   localparam int W  = 8;
   localparam int LW = 3;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0]  x;
   logic [LW-1:0] pos;
   logic          dir, use_ptr;

   logic          vld2, rdy2, ovld2, ordy2, any2;
   logic [W-1:0]  xo2, y2;
   logic [LW-1:0] poso2, enc2, ptr2;
   logic          vld1, rdy1, ovld1, ordy1, any1;
   logic [W-1:0]  xo1, y1;
   logic [LW-1:0] poso1, enc1, ptr1;

   s_rr_pipe #(.W(W), .P_STAGES(2)) dut2 (
      .clk(clk), .arst_n(arst_n), .in_vld_i(vld2), .in_rdy_o(rdy2),
      .x_i(x), .pos_i(pos), .dir_i(dir), .use_ptr_i(use_ptr),
      .out_vld_o(ovld2), .out_rdy_i(ordy2), .x_o(xo2), .pos_o(poso2),
      .any_o(any2), .y_o(y2), .y_enc_o(enc2), .ptr_o(ptr2)
   );

   s_rr_pipe #(.W(W), .P_STAGES(1)) dut1 (
      .clk(clk), .arst_n(arst_n), .in_vld_i(vld1), .in_rdy_o(rdy1),
      .x_i(x), .pos_i(pos), .dir_i(dir), .use_ptr_i(use_ptr),
      .out_vld_o(ovld1), .out_rdy_i(ordy1), .x_o(xo1), .pos_o(poso1),
      .any_o(any1), .y_o(y1), .y_enc_o(enc1), .ptr_o(ptr1)
   );

   typedef struct {
      logic [W-1:0]  x;
      logic [LW-1:0] pos;
      logic          any;
      logic [W-1:0]  y;
      logic [LW-1:0] enc;
      logic [LW-1:0] ptr;
   } exp_t;

   exp_t q2[$];
   exp_t q1[$];
   int   mptr2 = 0;
   int   mptr1 = 0;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference search: scan distances from far to near so the nearest set bit wins.
   function automatic int ref_find(input logic [W-1:0] xv, input int p, input bit dv);
      int k;
      int r;
      r = 0;
      for (int d = W - 1; d >= 0; d--) begin
         k = dv ? (p - d + W) % W : (p + d) % W;
         if (xv[k]) r = k;
      end
      return r;
   endfunction

   task automatic push_exp(input int sel, input logic [W-1:0] xv, input int pv, input bit dv, input bit uv);
      exp_t e;
      int   p, k, mp;
      mp = (sel == 2) ? mptr2 : mptr1;
      p  = uv ? mp : pv;
      k  = ref_find(xv, p, dv);
      e.x   = xv;
      e.pos = LW'(p);
      e.any = (xv != '0);
      e.y   = '0;
      if (e.any) e.y[k] = 1'b1;
      e.enc = e.any ? LW'(k) : '0;
      if (uv && e.any) mp = dv ? (k + W - 1) % W : (k + 1) % W;
      e.ptr = LW'(mp);
      if (sel == 2) begin
         mptr2 = mp;
         q2.push_back(e);
      end else begin
         mptr1 = mp;
         q1.push_back(e);
      end
   endtask

   task automatic send(input int sel, input logic [W-1:0] xv, input int pv, input bit dv, input bit uv);
      bit ok;
      x = xv; pos = LW'(pv); dir = dv; use_ptr = uv;
      if (sel == 2) vld2 = 1'b1; else vld1 = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if ((sel == 2) ? rdy2 : rdy1) begin
            ok = 1'b1;
            push_exp(sel, xv, pv, dv, uv);
         end
         @(posedge clk); #1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle();
      vld2 = 1'b0;
      vld1 = 1'b0;
   endtask

   task automatic drain(input int sel);
      for (int c = 0; c < 100 && ((sel == 2) ? q2.size() : q1.size()) != 0; c++) @(posedge clk);
      #1;
      chk("drain_left", (sel == 2) ? q2.size() : q1.size(), 0);
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      #2;
      arst_n = 1'b1;
      q2.delete(); q1.delete();
      mptr2 = 0; mptr1 = 0;
      @(posedge clk); #1;
   endtask

   task automatic stall(input int sel, input int nbuf);
      logic [W-1:0] nx;
      if (sel == 2) ordy2 = 1'b0; else ordy1 = 1'b0;
      for (int i = 0; i < nbuf; i++) send(sel, W'($urandom_range(1, 255)), i, i % 2, 1);
      nx = W'($urandom_range(1, 255));
      x = nx; pos = 3'd5; dir = 1'b0; use_ptr = 1'b1;
      if (sel == 2) vld2 = 1'b1; else vld1 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_in_rdy", (sel == 2) ? rdy2 : rdy1, 0);
         chk("stall_out_vld", (sel == 2) ? ovld2 : ovld1, 1);
         chk("stall_x", (sel == 2) ? xo2 : xo1, (sel == 2) ? q2[0].x : q1[0].x);
         chk("stall_enc", (sel == 2) ? enc2 : enc1, (sel == 2) ? q2[0].enc : q1[0].enc);
         chk("stall_ptr", (sel == 2) ? ptr2 : ptr1, (sel == 2) ? q2[0].ptr : q1[0].ptr);
      end
      @(posedge clk); #1;
      if (sel == 2) ordy2 = 1'b1; else ordy1 = 1'b1;
      send(sel, nx, 5, 0, 1);
      send(sel, W'($urandom_range(0, 255)), 2, 1, 1);
      send(sel, W'($urandom_range(0, 255)), 7, 0, 0);
      idle();
      drain(sel);
   endtask

   // Output monitor: every transfer must match the oldest expected beat.
   always @(negedge clk) begin
      exp_t e;
      if (arst_n && ovld2 && ordy2) begin
         if (q2.size() == 0) chk("p2_unexpected_beat", 1, 0);
         else begin
            e = q2.pop_front();
            chk("p2_x", xo2, e.x);     chk("p2_pos", poso2, e.pos);
            chk("p2_any", any2, e.any); chk("p2_y", y2, e.y);
            chk("p2_enc", enc2, e.enc); chk("p2_ptr", ptr2, e.ptr);
         end
      end
      if (arst_n && ovld1 && ordy1) begin
         if (q1.size() == 0) chk("p1_unexpected_beat", 1, 0);
         else begin
            e = q1.pop_front();
            chk("p1_x", xo1, e.x);     chk("p1_pos", poso1, e.pos);
            chk("p1_any", any1, e.any); chk("p1_y", y1, e.y);
            chk("p1_enc", enc1, e.enc); chk("p1_ptr", ptr1, e.ptr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      x = '0; pos = '0; dir = 1'b0; use_ptr = 1'b0;
      vld2 = 1'b0; vld1 = 1'b0; ordy2 = 1'b0; ordy1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_rdy2", rdy2, 1);  chk("rst_out_vld2", ovld2, 0);
      chk("rst_ptr2", ptr2, 0);     chk("rst_any2", any2, 0);
      chk("rst_y2", y2, 0);         chk("rst_enc2", enc2, 0);
      chk("rst_x2", xo2, 0);        chk("rst_pos2", poso2, 0);
      chk("rst_in_rdy1", rdy1, 1);  chk("rst_out_vld1", ovld1, 0);
      arst_n = 1'b1;
      ordy2 = 1'b1; ordy1 = 1'b1;
      @(posedge clk); #1;

      send(2, 8'h24, 3, 0, 0);
      idle();
      chk("lat_early_vld", ovld2, 0);
      @(posedge clk); #1;
      chk("lat_vld", ovld2, 1);   chk("lat_any", any2, 1);
      chk("lat_y", y2, 8'h20);    chk("lat_enc", enc2, 5);
      chk("lat_pos", poso2, 3);   chk("lat_x", xo2, 8'h24);
      chk("lat_ptr", ptr2, 0);
      drain(2);

      send(2, 8'h24, 3, 1, 0);
      send(2, 8'h24, 1, 1, 0);
      send(2, 8'h24, 6, 0, 0);
      idle();
      drain(2);

      do_reset();
      for (int i = 0; i < 4; i++) send(2, 8'hFF, 0, 0, 1);
      idle();
      drain(2);
      chk("rr_ptr_after_four", ptr2, 4);
      send(2, 8'h11, 0, 1, 1);
      idle();
      drain(2);
      chk("rr_ptr_desc", ptr2, 3);
      send(2, 8'h00, 0, 0, 1);
      idle();
      drain(2);
      chk("empty_ptr_hold", ptr2, 3);

      stall(2, 2);
      stall(1, 1);

      do_reset();
      send(2, 8'hFF, 0, 0, 1);
      send(2, 8'hFF, 0, 0, 1);
      idle();
      #2;
      chk("mid_ptr_before_rst", ptr2, 1);
      arst_n = 1'b0;
      #1;
      chk("mid_rst_out_vld", ovld2, 0);
      chk("mid_rst_ptr", ptr2, 0);
      chk("mid_rst_in_rdy", rdy2, 1);
      q2.delete();
      mptr2 = 0;
      arst_n = 1'b1;
      @(posedge clk); #1;
      send(2, 8'h80, 0, 0, 0);
      idle();
      chk("post_rst_early_vld", ovld2, 0);
      @(posedge clk); #1;
      chk("post_rst_vld", ovld2, 1);
      chk("post_rst_enc", enc2, 7);
      drain(2);

      chk("final_q2_empty", q2.size(), 0);
      chk("final_q1_empty", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
